// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Arbitrates two register-file write-back ports (A = ALU, B = memory load)
//   onto a single registered write stage. Round-robin between the ports when
//   both request, one write per cycle, with a stall that freezes a pending
//   write in place. Writes to register 0 are accepted but discarded and
//   counted.
//
// Ports
//   clk_i                     single clock, rising edge
//   reset_i                   synchronous active-high reset
//   a_valid_i/a_addr_i/a_data_i, a_ready_o   port A request / accept
//   b_valid_i/b_addr_i/b_data_i, b_ready_o   port B request / accept
//   stall_i                   register file cannot take a write this cycle
//   wr_en_o                   one-hot register write enables (registered)
//   wr_data_o                 write data for the enabled register (registered)
//   drop_cnt_o                saturating count of accepted writes to register 0
//   collide_o                 one-cycle pulse: both ports hit the same nonzero
//                             register in the same cycle
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          RR_INIT    = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  a_valid_i,
    input  logic [4:0]            a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    output logic                  a_ready_o,
    input  logic                  b_valid_i,
    input  logic [4:0]            b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  b_ready_o,
    input  logic                  stall_i,
    output logic [31:0]           wr_en_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [7:0]            drop_cnt_o,
    output logic                  collide_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    // 5-to-32 one-hot decode of a register address
    function automatic logic [31:0] decode5(input logic [4:0] addr);
        decode5 = 32'd1 << addr;
    endfunction

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;          // 0: A favoured, 1: B favoured
    logic [31:0]           wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]            drop_q, drop_d;
    logic                  collide_q, collide_d;

    logic                  out_pend_s;
    logic                  grant_ok_s;
    logic                  a_ready_s, b_ready_s;
    logic                  xfer_a_s, xfer_b_s, xfer_s;
    logic [4:0]            x_addr_s;
    logic [DATA_WIDTH-1:0] x_data_s;

    // State register: FSM, pointer, output stage, drop counter, collision flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= RR_INIT;
            wr_en_q   <= 32'd0;
            wr_data_q <= {DATA_WIDTH{1'b0}};
            drop_q    <= 8'd0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
            collide_q <= collide_d;
        end
    end

    // Next-state logic: output stage, pointer, drop counter, collision detect
    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        ptr_d     = ptr_q;
        drop_d    = drop_q;
        collide_d = a_valid_i & b_valid_i & (a_addr_i == b_addr_i) & (a_addr_i != 5'd0);

        case (state_q)
            ST_IDLE: begin
                // IDLE accepts even under stall; the write then holds in WRITE
                if (xfer_s && (x_addr_s != 5'd0)) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = decode5(x_addr_s);
                    wr_data_d = x_data_s;
                end else begin
                    state_d = ST_IDLE;
                    wr_en_d = 32'd0;
                end
            end
            ST_WRITE: begin
                if (stall_i) begin
                    // Held write: no transfer can happen, keep everything
                    state_d = ST_WRITE;
                end else if (xfer_s && (x_addr_s != 5'd0)) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = decode5(x_addr_s);
                    wr_data_d = x_data_s;
                end else begin
                    state_d = ST_IDLE;
                    wr_en_d = 32'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wr_en_d = 32'd0;
            end
        endcase

        // Only a transfer on the favoured port moves the pointer
        if ((xfer_a_s && !ptr_q) || (xfer_b_s && ptr_q)) begin
            ptr_d = ~ptr_q;
        end else begin
            ptr_d = ptr_q;
        end

        if (xfer_s && (x_addr_s == 5'd0) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Output logic: combinational grants and registered output drive
    always_comb begin
        out_pend_s = (state_q == ST_WRITE);
        grant_ok_s = !reset_i && !(stall_i && out_pend_s);
        // A lone requester always wins; on contention the pointer decides
        a_ready_s  = grant_ok_s & a_valid_i & (!b_valid_i | !ptr_q);
        b_ready_s  = grant_ok_s & b_valid_i & (!a_valid_i |  ptr_q);
        xfer_a_s   = a_valid_i & a_ready_s;
        xfer_b_s   = b_valid_i & b_ready_s;
        xfer_s     = xfer_a_s | xfer_b_s;
        if (xfer_b_s) begin
            x_addr_s = b_addr_i;
            x_data_s = b_data_i;
        end else begin
            x_addr_s = a_addr_i;
            x_data_s = a_data_i;
        end
        a_ready_o  = a_ready_s;
        b_ready_o  = b_ready_s;
        wr_en_o    = wr_en_q;
        wr_data_o  = wr_data_q;
        drop_cnt_o = drop_q;
        collide_o  = collide_q;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0, stall = 1'b0;
    logic [4:0]    a_addr = 5'd0, b_addr = 5'd0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, collide;
    logic [31:0]   wr_en;
    logic [DW-1:0] wr_data;
    logic [7:0]    drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .RR_INIT(1'b0)) dut (
        .clk_i(clk), .reset_i(reset),
        .a_valid_i(a_valid), .a_addr_i(a_addr), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_addr_i(b_addr), .b_data_i(b_data), .b_ready_o(b_ready),
        .stall_i(stall), .wr_en_o(wr_en), .wr_data_o(wr_data),
        .drop_cnt_o(drop_cnt), .collide_o(collide)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The pending write is kept as (register number, data); enables are derived.
    bit          m_pend = 1'b0;
    int          m_reg  = 0;
    logic [DW-1:0] m_data = '0;
    bit          m_favb = 1'b0;   // favoured port is B
    int          m_drop = 0;
    bit          m_coll = 1'b0;

    // Which port is granted this cycle: returns {b, a}
    function automatic logic [1:0] model_grant(input bit rst, input bit st, input bit pend,
                                               input bit favb, input bit av, input bit bv);
        if (rst || (st && pend)) return 2'b00;
        if (av && bv)            return favb ? 2'b10 : 2'b01;
        return {bv, av};
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        int addr;
        g = model_grant(reset, stall, m_pend, m_favb, a_valid, b_valid);
        if (reset) begin
            m_pend = 1'b0; m_reg = 0; m_data = '0; m_favb = 1'b0; m_drop = 0; m_coll = 1'b0;
        end else begin
            m_coll = a_valid && b_valid && (a_addr == b_addr) && (a_addr != 5'd0);
            if (g != 2'b00) begin
                if ((g[0] && !m_favb) || (g[1] && m_favb)) m_favb = !m_favb;
            end
            if (stall && m_pend) begin
                // held write, nothing changes
            end else if (g != 2'b00) begin
                addr = g[1] ? int'(b_addr) : int'(a_addr);
                if (addr == 0) begin
                    m_pend = 1'b0;
                    if (m_drop < 255) m_drop = m_drop + 1;
                end else begin
                    m_pend = 1'b1;
                    m_reg  = addr;
                    m_data = g[1] ? b_data : a_data;
                end
            end else begin
                m_pend = 1'b0;
            end
        end
    end

    // Single compare process, away from the active edge
    always @(negedge clk) begin
        logic [1:0] g;
        logic [31:0] exp_en;
        if (chk_en) begin
            g = model_grant(reset, stall, m_pend, m_favb, a_valid, b_valid);
            exp_en = m_pend ? (32'd1 << m_reg) : 32'd0;
            check("m_a_ready", {63'd0, a_ready}, {63'd0, g[0]});
            check("m_b_ready", {63'd0, b_ready}, {63'd0, g[1]});
            check("m_wr_en",   {32'd0, wr_en}, {32'd0, exp_en});
            check("m_wr_data", {32'd0, wr_data}, {32'd0, m_data});
            check("m_drop",    {56'd0, drop_cnt}, 64'(m_drop));
            check("m_collide", {63'd0, collide}, {63'd0, m_coll});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; b_valid = 1'b0; stall = 1'b0;
        a_addr = 5'd0; b_addr = 5'd0; a_data = '0; b_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_seq [4];
        bit          exp_a   [4];
        logic [31:0] held;

        // Reset: readies stay low even with a request present
        reset = 1'b1; a_valid = 1'b1; a_addr = 5'd4;
        tick();
        tick();
        #1;
        check("rst_a_ready", {63'd0, a_ready}, 64'd0);
        check("rst_wr_en",   {32'd0, wr_en}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check("rst_drop",    {56'd0, drop_cnt}, 64'd0);
        check("rst_collide", {63'd0, collide}, 64'd0);
        chk_en = 1'b1;
        do_reset();

        // Port A alone, addr 5
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1 check("single_a_ready", {63'd0, a_ready}, 64'd1);
        tick();
        a_valid = 1'b0;
        #1 check("single_wr_en", {32'd0, wr_en}, 64'h20);
        check("single_wr_data", {32'd0, wr_data}, 64'hDEADBEEF);
        tick();
        #1 check("single_idle", {32'd0, wr_en}, 64'd0);

        // Both ports for 4 cycles: A, B, A, B
        do_reset();
        exp_a   = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_seq = '{32'h2, 32'h4, 32'h2, 32'h4};
        a_valid = 1'b1; a_addr = 5'd1; b_valid = 1'b1; b_addr = 5'd2;
        for (int i = 0; i < 4; i++) begin
            a_data = 32'hA0 + 32'(i); b_data = 32'hB0 + 32'(i);
            #1 check("rr_a_ready", {63'd0, a_ready}, {63'd0, exp_a[i]});
            check("rr_b_ready", {63'd0, b_ready}, {63'd0, !exp_a[i]});
            tick();
            #1 check("rr_wr_en", {32'd0, wr_en}, {32'd0, exp_seq[i]});
            check("rr_wr_data", {32'd0, wr_data}, exp_a[i] ? 64'hA0 + 64'(i) : 64'hB0 + 64'(i));
        end
        idle_inputs();

        // Stall hold: addr 3 accepted from IDLE under stall, held 3 cycles
        do_reset();
        stall = 1'b1; a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1234_5678;
        #1 check("stall_idle_accept", {63'd0, a_ready}, 64'd1);
        tick();
        a_addr = 5'd4; a_data = 32'h0BAD_F00D;
        held = wr_data;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall = 1'b0;
            #1 check("stall_wr_en", {32'd0, wr_en}, 64'h8);
            check("stall_wr_data", {32'd0, wr_data}, 64'h1234_5678);
            check("stall_data_stable", {32'd0, wr_data}, {32'd0, held});
            check("stall_a_ready", {63'd0, a_ready}, (i == 2) ? 64'd1 : 64'd0);
            tick();
        end
        a_valid = 1'b0;
        #1 check("stall_next_write", {32'd0, wr_en}, 64'h10);

        // 260 writes to register 0
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0;
        for (int i = 0; i < 260; i++) begin
            a_data = $urandom;
            tick();
            if (i == 99) check("drop_100", {56'd0, drop_cnt}, 64'd100);
            if (wr_en !== 32'd0) check("drop_wr_en", {32'd0, wr_en}, 64'd0);
        end
        #1 check("drop_sat", {56'd0, drop_cnt}, 64'd255);
        idle_inputs();

        // Collision on addr 7
        do_reset();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h111;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h222;
        #1 check("coll_a_first", {63'd0, a_ready}, 64'd1);
        tick();
        a_valid = 1'b0;
        #1 check("coll_pulse", {63'd0, collide}, 64'd1);
        check("coll_wr1", {32'd0, wr_en}, 64'h80);
        check("coll_data1", {32'd0, wr_data}, 64'h111);
        check("coll_b_second", {63'd0, b_ready}, 64'd1);
        tick();
        b_valid = 1'b0;
        #1 check("coll_pulse_end", {63'd0, collide}, 64'd0);
        check("coll_wr2", {32'd0, wr_en}, 64'h80);
        check("coll_data2", {32'd0, wr_data}, 64'h222);
        tick();
        #1 check("coll_idle", {32'd0, wr_en}, 64'd0);

        // Reset while stalled in WRITE
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0;           // drop=1, pointer -> B
        tick();
        a_addr = 5'd9; a_data = 32'h99; stall = 1'b1;   // A not favoured: pointer stays B
        tick();
        a_valid = 1'b0;
        tick();
        #1 check("pre_rst_hold", {32'd0, wr_en}, 64'h200);
        reset = 1'b1; a_valid = 1'b1; a_addr = 5'd6;
        #1 check("rst_ready_low", {63'd0, a_ready}, 64'd0);
        tick();
        reset = 1'b0; stall = 1'b0;
        #1 check("rst_discard", {32'd0, wr_en}, 64'd0);
        check("rst_drop_clr", {56'd0, drop_cnt}, 64'd0);
        b_valid = 1'b1; b_addr = 5'd6;
        #1 check("rst_ptr_a", {63'd0, a_ready}, 64'd1);
        tick();
        idle_inputs();

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            a_valid = $urandom_range(0, 1);
            b_valid = $urandom_range(0, 1);
            a_addr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            b_addr  = ($urandom_range(0, 3) == 0) ? a_addr : 5'($urandom);
            a_data  = $urandom;
            b_data  = $urandom;
            tick();
        end
        idle_inputs();
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
